// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// State encoding is fixed so traces line up with the decode-side tools.
package pc_fetch_sequencer_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HOLD   = 3'd4,
      ST_HALTED = 3'd5
   } state_t;

endpackage

// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: PC stepping, imem read sequencing, IR hold for decode.
// Redirects load the PC and squash whatever read is still in flight.
module pc_fetch_sequencer
   import pc_fetch_sequencer_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              halt,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_en,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_load_val,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              ir_valid,
   output logic [DATA_W-1:0] ir_data,
   output logic [ADDR_W-1:0] ir_pc,
   input  logic              ir_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              busy
);

   state_t state, nxt;
   logic   cap_pc;
   logic   cap_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         ir_valid <= 1'b0;
         busy     <= 1'b0;
         ir_data  <= '0;
         ir_pc    <= '0;
      end else begin
         state    <= nxt;
         ir_valid <= (nxt == ST_HOLD);
         busy     <= !(nxt inside {ST_IDLE, ST_HALTED});
         if (cap_pc)
            ir_pc <= pc;
         if (cap_data)
            ir_data <= mem_rdata;
      end
   end

   always_comb begin
      nxt      = state;
      pc_en    = 1'b0;
      pc_load  = 1'b0;
      mem_req  = 1'b0;
      cap_pc   = 1'b0;
      cap_data = 1'b0;
      unique case (state)
         ST_IDLE, ST_HALTED: begin
            if (run && !halt)
               nxt = ST_REQ;
         end
         ST_REQ: begin
            if (redirect) begin
               pc_load = 1'b1;
            end else begin
               mem_req = 1'b1;
               if (mem_gnt) begin
                  pc_en  = 1'b1;
                  cap_pc = 1'b1;
                  nxt    = ST_WAIT;
               end else if (halt) begin
                  nxt = ST_HALTED;
               end
            end
         end
         ST_WAIT: begin
            // a redirect racing the read data drops it outright
            if (redirect) begin
               pc_load = 1'b1;
               nxt     = mem_rvalid ? ST_REQ : ST_DRAIN;
            end else if (mem_rvalid) begin
               cap_data = 1'b1;
               nxt      = ST_HOLD;
            end
         end
         ST_DRAIN: begin
            pc_load = redirect;
            if (mem_rvalid)
               nxt = ST_REQ;
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_load = 1'b1;
               nxt     = ST_REQ;
            end else if (ir_ready) begin
               nxt = halt ? ST_HALTED : ST_REQ;
            end
         end
         default: nxt = ST_IDLE;
      endcase
   end

   assign pc_load_val = pc_load ? redirect_pc : '0;
   assign mem_addr    = mem_req ? pc : '0;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: vector table, corner sequences, random run.
// Pairs the DUT with a behavioural PC register and a latency-programmable imem.
module tb_pc_fetch_sequencer;
   import pc_fetch_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset, run, halt;
   logic [15:0] pc;
   logic        pc_en, pc_load;
   logic [15:0] pc_load_val;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_gnt, mem_rvalid;
   logic [15:0] mem_rdata;
   logic        ir_valid;
   logic [15:0] ir_data, ir_pc;
   logic        ir_ready, redirect;
   logic [15:0] redirect_pc;
   logic        busy;

   always #5 clk = ~clk;

   pc_fetch_sequencer dut (
      .clk(clk), .reset(reset), .run(run), .halt(halt), .pc(pc),
      .pc_en(pc_en), .pc_load(pc_load), .pc_load_val(pc_load_val),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc),
      .ir_ready(ir_ready), .redirect(redirect),
      .redirect_pc(redirect_pc), .busy(busy)
   );

   int total = 0;
   int bad = 0;

   // memory model state
   bit          mb;
   int          mcnt;
   logic [15:0] maddr;
   int unsigned gpct = 100;
   int unsigned lmin = 1, lmax = 1;
   bit          dead;

   // outputs sampled in the current cycle
   logic        s_req, s_en, s_ld, s_v, s_busy, s_rv;
   logic [15:0] s_addr, s_ldv, s_data, s_irpc;

   typedef struct {
      logic        run, halt, rdy, rdr;
      logic [15:0] rpc;
      logic [4:0]  exp;
      logic [15:0] eaddr, eirpc;
   } vec_t;

   vec_t tv[28];

   function automatic logic [15:0] f(input logic [15:0] a);
      return (a ^ 16'hA5C3) + 16'h0101;
   endfunction

   function automatic vec_t mk(input logic r, h, y, d,
                               input logic [15:0] rp,
                               input logic [4:0] e,
                               input logic [15:0] ea, ei);
      vec_t v;
      v.run = r; v.halt = h; v.rdy = y; v.rdr = d;
      v.rpc = rp; v.exp = e; v.eaddr = ea; v.eirpc = ei;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // one clock cycle, entered and left at the falling edge
   task automatic cyc();
      logic g, rv;
      #1;
      rv = mb && (mcnt == 0);
      mem_rvalid = rv;
      mem_rdata = rv ? (dead ? 16'hDEAD : f(maddr)) : 16'($urandom);
      g = mem_req && !mb && ($urandom_range(99, 0) < gpct);
      mem_gnt = g;
      #1;
      s_req = mem_req; s_addr = mem_addr; s_en = pc_en; s_ld = pc_load;
      s_ldv = pc_load_val; s_v = ir_valid; s_data = ir_data;
      s_irpc = ir_pc; s_busy = busy; s_rv = rv;
      chk("strobe_excl", 16'(s_en & s_ld), 16'h0);
      if (s_req)
         chk("addr_is_pc", s_addr, pc);
      @(posedge clk);
      #1;
      if (rv)
         mb = 1'b0;
      else if (mb)
         mcnt--;
      if (g) begin
         mb = 1'b1;
         maddr = s_addr;
         mcnt = int'($urandom_range(lmax, lmin)) - 1;
      end
      if (s_ld)
         pc = s_ldv;
      else if (s_en)
         pc = pc + 16'h1;
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [15:0] p);
      reset = 1'b0; run = 1'b0; halt = 1'b0; ir_ready = 1'b0;
      redirect = 1'b0; redirect_pc = '0; mem_gnt = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = '0; mb = 1'b0; mcnt = 0;
      maddr = '0; dead = 1'b0; pc = p;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      logic [15:0] expnext;
      int          acc, at;
      bit          seen_dead, got_v, clean;

      // exp = {mem_req, pc_en, pc_load, ir_valid, busy}
      tv[0]  = mk(0,0,1,0,16'h0,5'b00000,16'h0,16'h0);
      tv[1]  = mk(1,0,1,0,16'h0,5'b00000,16'h0,16'h0);
      tv[2]  = mk(1,0,1,0,16'h0,5'b11001,16'h0010,16'h0);
      tv[3]  = mk(1,0,1,0,16'h0,5'b00001,16'h0,16'h0);
      tv[4]  = mk(1,0,1,0,16'h0,5'b00011,16'h0,16'h0010);
      tv[5]  = mk(1,0,1,0,16'h0,5'b11001,16'h0011,16'h0);
      tv[6]  = mk(1,0,1,0,16'h0,5'b00001,16'h0,16'h0);
      tv[7]  = mk(1,0,1,0,16'h0,5'b00011,16'h0,16'h0011);
      tv[8]  = mk(1,0,1,0,16'h0,5'b11001,16'h0012,16'h0);
      tv[9]  = mk(1,0,1,0,16'h0,5'b00001,16'h0,16'h0);
      tv[10] = mk(1,0,0,0,16'h0,5'b00011,16'h0,16'h0012);
      tv[11] = mk(1,0,0,0,16'h0,5'b00011,16'h0,16'h0012);
      tv[12] = mk(1,0,0,0,16'h0,5'b00011,16'h0,16'h0012);
      tv[13] = mk(1,0,0,0,16'h0,5'b00011,16'h0,16'h0012);
      tv[14] = mk(1,0,1,0,16'h0,5'b00011,16'h0,16'h0012);
      tv[15] = mk(1,0,1,0,16'h0,5'b11001,16'h0013,16'h0);
      tv[16] = mk(1,0,1,0,16'h0,5'b00001,16'h0,16'h0);
      tv[17] = mk(1,1,0,0,16'h0,5'b00011,16'h0,16'h0013);
      tv[18] = mk(1,1,1,0,16'h0,5'b00011,16'h0,16'h0013);
      tv[19] = mk(1,1,1,0,16'h0,5'b00000,16'h0,16'h0);
      tv[20] = mk(1,0,1,0,16'h0,5'b00000,16'h0,16'h0);
      tv[21] = mk(1,0,1,0,16'h0,5'b11001,16'h0014,16'h0);
      tv[22] = mk(1,0,1,0,16'h0,5'b00001,16'h0,16'h0);
      tv[23] = mk(1,0,1,1,16'h0040,5'b00111,16'h0,16'h0014);
      tv[24] = mk(1,0,1,0,16'h0,5'b11001,16'h0040,16'h0);
      tv[25] = mk(1,0,1,0,16'h0,5'b00001,16'h0,16'h0);
      tv[26] = mk(1,0,1,0,16'h0,5'b00011,16'h0,16'h0040);
      tv[27] = mk(1,0,1,0,16'h0,5'b11001,16'h0041,16'h0);

      reset = 1'b0; run = 1'b0; halt = 1'b0; ir_ready = 1'b0;
      redirect = 1'b0; redirect_pc = '0; mem_gnt = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = '0; mb = 1'b0; mcnt = 0;
      maddr = '0; dead = 1'b0; pc = 16'h0010;
      repeat (2) @(negedge clk);
      chk("reset_outs", 16'(|{pc_en, pc_load, pc_load_val, mem_req,
          mem_addr, ir_valid, ir_data, ir_pc, busy}), 16'h0);
      reset = 1'b1;

      for (int i = 0; i < 28; i++) begin
         run = tv[i].run; halt = tv[i].halt; ir_ready = tv[i].rdy;
         redirect = tv[i].rdr; redirect_pc = tv[i].rpc;
         cyc();
         chk($sformatf("row%0d_flags", i),
             16'({s_req, s_en, s_ld, s_v, s_busy}), 16'(tv[i].exp));
         if (tv[i].exp[4])
            chk($sformatf("row%0d_addr", i), s_addr, tv[i].eaddr);
         if (tv[i].exp[2])
            chk($sformatf("row%0d_ldv", i), s_ldv, tv[i].rpc);
         if (tv[i].exp[1]) begin
            chk($sformatf("row%0d_irpc", i), s_irpc, tv[i].eirpc);
            chk($sformatf("row%0d_data", i), s_data, f(tv[i].eirpc));
         end
      end

      // redirect while the read is outstanding; its data must vanish
      do_reset(16'h0100);
      lmin = 3; lmax = 3; dead = 1'b1; run = 1'b1; ir_ready = 1'b1;
      cyc();
      cyc();
      chk("rw_gnt", 16'({s_req, s_en}), 16'h3);
      redirect = 1'b1; redirect_pc = 16'h0200;
      cyc();
      chk("rw_strobe", 16'({s_ld, s_en}), 16'h2);
      chk("rw_ldv", s_ldv, 16'h0200);
      redirect = 1'b0;
      seen_dead = 1'b0; got_v = 1'b0; at = -1;
      for (int k = 0; k < 12; k++) begin
         cyc();
         if (s_v && s_data == 16'hDEAD)
            seen_dead = 1'b1;
         if (s_req && at < 0) begin
            at = k;
            dead = 1'b0;
            chk("rw_next_addr", s_addr, 16'h0200);
         end
         if (s_v && s_irpc == 16'h0200 && s_data == f(16'h0200))
            got_v = 1'b1;
      end
      chk("rw_req_cycle", 16'(at), 16'h2);
      chk("rw_no_dead", 16'(seen_dead), 16'h0);
      chk("rw_refetch", 16'(got_v), 16'h1);

      // asynchronous reset in the middle of a read
      do_reset(16'h0300);
      lmin = 3; lmax = 3; run = 1'b1; ir_ready = 1'b1;
      cyc();
      cyc();
      chk("rm_gnt", 16'(s_en), 16'h1);
      run = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rm_outs_zero", 16'(|{pc_en, pc_load, pc_load_val, mem_req,
          mem_addr, ir_valid, ir_data, ir_pc, busy}), 16'h0);
      @(negedge clk);
      cyc();
      reset = 1'b1;
      clean = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         if (s_v || s_busy || s_req || s_data != 16'h0 || s_irpc != 16'h0)
            clean = 1'b0;
      end
      chk("rm_late_rvalid_ignored", 16'(clean), 16'h1);
      run = 1'b1;
      cyc();
      cyc();
      chk("rm_resume_req", 16'(s_req), 16'h1);
      chk("rm_resume_addr", s_addr, 16'h0301);

      // random traffic against the accepted-instruction stream model
      do_reset(16'($urandom));
      gpct = 60; lmin = 1; lmax = 3; run = 1'b1;
      expnext = pc; acc = 0;
      for (int k = 0; k < 3000; k++) begin
         ir_ready = ($urandom_range(9, 0) < 7);
         redirect = busy && ($urandom_range(9, 0) == 0);
         redirect_pc = 16'($urandom);
         cyc();
         chk("rnd_load", 16'(s_ld), 16'(redirect));
         if (s_v && ir_ready) begin
            chk("rnd_irpc", s_irpc, expnext);
            chk("rnd_data", s_data, f(s_irpc));
            expnext = s_irpc + 16'h1;
            acc++;
         end
         if (redirect)
            expnext = redirect_pc;
      end
      chk("rnd_progress", 16'(acc >= 200), 16'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
